// File: rtl/reg_file_2r1w.sv
// DEPTH x WIDTH register file: one byte-strobed write port, two combinational read ports,
// and a one-entry-per-cycle clear engine. Define REG_FILE_BYPASS_EN for write-through forwarding.
module reg_file_2r1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cs,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic [WIDTH/8-1:0]         i_wstrb,
    input  logic                       i_clr,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr_a,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr_b,
    output logic [WIDTH-1:0]           o_rdata_a,
    output logic [WIDTH-1:0]           o_rdata_b,
    output logic                       o_busy
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NB     = WIDTH / 8;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_ptr;
    logic                  r_busy;
    logic [WIDTH-1:0]      r_mem [DEPTH];

    logic                  w_wa_ok;
    logic                  w_wr_acc;
    logic [1:0][ADDR_W-1:0] w_raddr;
    logic [1:0][WIDTH-1:0]  w_rdata;

    // Dropped writes: out of range, hardwired zero entry, empty strobe, or clear running
    assign w_wa_ok  = (32'(i_waddr) < DEPTH) && !((ZERO_REG != 0) && (i_waddr == '0));
    assign w_wr_acc = (r_state == IDLE) && i_cs && i_we && w_wa_ok && (|i_wstrb);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_cs && i_clr) w_state_nxt = CLEAR;
            CLEAR:   if (r_ptr == LAST) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(negedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == CLEAR);
            if (r_state == CLEAR) begin
                r_mem[r_ptr] <= '0;
                r_ptr        <= (r_ptr == LAST) ? '0 : r_ptr + ADDR_W'(1);
            end else begin
                r_ptr <= '0;
                if (w_wr_acc) begin
                    for (int b = 0; b < NB; b++)
                        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic [WIDTH-1:0] w_fwd;
    always_comb begin
        w_fwd = r_mem[i_waddr];
        for (int b = 0; b < NB; b++)
            if (i_wstrb[b]) w_fwd[8*b +: 8] = i_wdata[8*b +: 8];
    end
`endif

    assign w_raddr[0] = i_raddr_a;
    assign w_raddr[1] = i_raddr_b;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            w_rdata[p] = '0;
            if ((32'(w_raddr[p]) < DEPTH) && !((ZERO_REG != 0) && (w_raddr[p] == '0)))
                w_rdata[p] = r_mem[w_raddr[p]];
`ifdef REG_FILE_BYPASS_EN
            if (w_wr_acc && (w_raddr[p] == i_waddr))
                w_rdata[p] = w_fwd;
`endif
        end
    end

    assign o_rdata_a = w_rdata[0];
    assign o_rdata_b = w_rdata[1];
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: a DEPTH=32 instance plus a DEPTH=20 instance for range checks.
module tb_reg_file_2r1w;
    logic        clk = 1'b1;
    logic        rst, cs, we, clr;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata, rdata_a, rdata_b;
    logic [3:0]  wstrb;
    logic        busy;
    logic        we2, busy2;
    logic [4:0]  waddr2, raddr2_a, raddr2_b;
    logic [31:0] rdata2_a, rdata2_b;

    int n_chk = 0;
    int n_err = 0;
    int cnt;

    always #5 clk = ~clk;

    reg_file_2r1w u_dut (
        .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_we(we), .i_waddr(waddr),
        .i_wdata(wdata), .i_wstrb(wstrb), .i_clr(clr),
        .i_raddr_a(raddr_a), .i_raddr_b(raddr_b),
        .o_rdata_a(rdata_a), .o_rdata_b(rdata_b), .o_busy(busy)
    );

    reg_file_2r1w #(.WIDTH(32), .DEPTH(20)) u_d20 (
        .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_we(we2), .i_waddr(waddr2),
        .i_wdata(wdata), .i_wstrb(wstrb), .i_clr(clr),
        .i_raddr_a(raddr2_a), .i_raddr_b(raddr2_b),
        .o_rdata_a(rdata2_a), .o_rdata_b(rdata2_b), .o_busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    // Active edge is the falling edge; stimulus and sampling happen 1ns after it
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        waddr = a; wdata = d; wstrb = s; we = 1'b1;
        tick;
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; we = 1'b0; clr = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
        raddr_a = '0; raddr_b = '0; we2 = 1'b0; waddr2 = '0; raddr2_a = '0; raddr2_b = '0;
        tick;
        rst = 1'b1;
        raddr_a = 5'd5; raddr_b = 5'd31; #1;
        chk("rst_rd_a", rdata_a, 32'h0);
        chk("rst_rd_b", rdata_b, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);

        cs = 1'b1;
        wr(5'd7, 32'hDEADBEEF, 4'hF);
        raddr_a = 5'd7; raddr_b = 5'd8; #1;
        chk("full_wr", rdata_a, 32'hDEADBEEF);
        chk("neighbour", rdata_b, 32'h0);

        wr(5'd7, 32'h11223344, 4'b0101);
        #1 chk("strobe", rdata_a, 32'hDE22BE44);

        wr(5'd7, 32'hFFFFFFFF, 4'b0000);
        #1 chk("strb_zero", rdata_a, 32'hDE22BE44);

        cs = 1'b0;
        wr(5'd7, 32'h00000000, 4'hF);
        cs = 1'b1;
        #1 chk("cs_low", rdata_a, 32'hDE22BE44);

        // Same-cycle read of entry being written: forwarded only with the bypass build
        wr(5'd3, 32'hAAAAAAAA, 4'hF);
        raddr_a = 5'd3; raddr_b = 5'd3;
        waddr = 5'd3; wdata = 32'h55555555; wstrb = 4'b0011; we = 1'b1; #1;
`ifdef REG_FILE_BYPASS_EN
        chk("pre_edge_a", rdata_a, 32'hAAAA5555);
        chk("pre_edge_b", rdata_b, 32'hAAAA5555);
`else
        chk("pre_edge_a", rdata_a, 32'hAAAAAAAA);
        chk("pre_edge_b", rdata_b, 32'hAAAAAAAA);
`endif
        tick;
        we = 1'b0; #1;
        chk("post_edge", rdata_a, 32'hAAAA5555);

        raddr_a = 5'd0;
        waddr = 5'd0; wdata = 32'hFFFFFFFF; wstrb = 4'hF; we = 1'b1; #1;
        chk("zero_pre", rdata_a, 32'h0);
        tick;
        we = 1'b0; #1;
        chk("zero_post", rdata_a, 32'h0);

        waddr2 = 5'd19; wdata = 32'h12345678; wstrb = 4'hF; we2 = 1'b1;
        tick;
        waddr2 = 5'd25; wdata = 32'hFFFFFFFF; raddr2_a = 5'd25; #1;
        chk("oor_fwd", rdata2_a, 32'h0);
        tick;
        we2 = 1'b0;
        raddr2_b = 5'd19; #1;
        chk("oor_rd", rdata2_a, 32'h0);
        chk("d20_last", rdata2_b, 32'h12345678);
        for (int i = 0; i < 19; i++) begin
            raddr2_a = 5'(i); #1;
            chk("d20_untouched", rdata2_a, 32'h0);
        end

        for (int i = 1; i < 32; i++) wr(5'(i), 32'h1000_0000 + 32'(i), 4'hF);
        raddr_a = 5'd10; #1;
        chk("fill", rdata_a, 32'h1000000A);

        // Write on the start edge is performed, then overwritten once the pointer gets there
        clr = 1'b1; waddr = 5'd31; wdata = 32'hCAFEF00D; wstrb = 4'hF; we = 1'b1;
        tick;
        clr = 1'b0; we = 1'b0;
        raddr_a = 5'd31; #1;
        chk("clr_busy_rise", {31'b0, busy}, 32'h1);
        chk("clr_start_wr", rdata_a, 32'hCAFEF00D);

        cnt = 0;
        while (busy && cnt < 100) begin
            we = (cnt == 10); waddr = 5'd20; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
            clr = (cnt == 15);
            tick;
            cnt++;
            if (cnt == 10) begin
                raddr_a = 5'd9; raddr_b = 5'd10; #1;
                chk("mid_cleared", rdata_a, 32'h0);
                chk("mid_held", rdata_b, 32'h1000000A);
            end
            if (cnt == 11) begin
                raddr_a = 5'd20; #1;
                chk("mid_wr_drop", rdata_a, 32'h10000014);
            end
        end
        we = 1'b0; clr = 1'b0;
        chk("busy_len", 32'(cnt), 32'd32);
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i); #1;
            chk("all_clear", rdata_a, 32'h0);
        end

        wr(5'd5, 32'h5A5A5A5A, 4'hF);
        wr(5'd30, 32'hA5A5A5A5, 4'hF);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        tick; tick; tick;
        raddr_a = 5'd30; #1;
        chk("pre_rst_held", rdata_a, 32'hA5A5A5A5);
        rst = 1'b0;
        tick;
        raddr_a = 5'd5; raddr_b = 5'd30; #1;
        chk("rst_mid_busy", {31'b0, busy}, 32'h0);
        chk("rst_mid_e5", rdata_a, 32'h0);
        chk("rst_mid_e30", rdata_b, 32'h0);
        rst = 1'b1;
        tick;
        chk("rst_no_restart", {31'b0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised register file that succeeds the single 32-bit register.
- Holds DEPTH words of WIDTH bits.
- One synchronous write port with per-byte strobes and a chip select.
- Two independent combinational read ports.
- A sequenced clear engine that zeroes the array one entry per cycle.
- Sits in the CPU datapath as the general-purpose register bank. Read ports feed the operand latches; the write port is driven from writeback.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 32, number of entries; 2 to 256, need not be a power of 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- ZERO_REG, 1, 1 = entry 0 is hardwired to zero; 0 = entry 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on the falling edge, as in the rest of the datapath.
- rst  in  1  reset, synchronous, active-low; sampled on the falling edge of clk.
- cs  in  1  chip select; no write and no clear start takes effect when low.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- wstrb  in  WIDTH/8  byte write strobes; bit i enables wdata[8i+7:8i].
- clr  in  1  start clear sequence (level sampled).
- raddr_a  in  ADDR_W  read port A address.
- raddr_b  in  ADDR_W  read port B address.
- rdata_a  out  WIDTH  read port A data.
- rdata_b  out  WIDTH  read port B data.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset: rst==0 at a falling edge sets:
  - all entries to 0
  - FSM to IDLE
  - clear pointer to 0
  - busy to 0
  - It overrides every other input, including an in-progress clear.
- Reads: combinational, zero latency.
  - rdata_x = mem[raddr_x].
  - raddr_x >= DEPTH returns 0.
  - ZERO_REG=1 and raddr_x==0 returns 0.
  - Both ports may address the same entry.
- Write: at a falling edge, when rst==1, state==IDLE, cs==1 and we==1:
  - each byte with wstrb[i]==1 is updated; other bytes hold.
  - The new value is visible on the read ports immediately after that edge.
- Dropped writes (silently ignored):
  - waddr >= DEPTH
  - waddr==0 with ZERO_REG=1
  - wstrb==0
  - any write while state==CLEAR
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: falling edge with cs==1, clr==1, rst==1. Pointer is set to 0.
    - A write presented on that same edge is still performed.
    - The clear then overwrites that entry when the pointer reaches it.
  - CLEAR: each falling edge writes 0 to mem[ptr] and increments ptr.
    - When ptr==DEPTH-1, that entry is cleared and the FSM returns to IDLE; ptr resets to 0.
    - The sequence takes exactly DEPTH cycles.
  - clr is ignored while in CLEAR; no restart.
  - Reads during CLEAR return the current contents: entries below ptr read 0, the rest hold their old data.
- busy: equals (state==CLEAR), registered. It rises after the start edge and falls after the edge that clears the last entry.
- Without the bypass feature, a read of the entry being written returns the old value before the edge and the new value after it.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-through forwarding.
  - When a write is accepted this cycle and raddr_x==waddr, rdata_x returns the merged value before the edge: strobed bytes from wdata, other bytes from mem.
  - Forwarding is not applied to dropped writes, including zero-register and out-of-range targets.
- Undefined: no forwarding; reads reflect stored contents only.

Test Plan:
- Reset then read: rst=0 for 1 edge, then rst=1. raddr_a=5, raddr_b=31 -> rdata_a=0, rdata_b=0, busy=0.
- Full write and read-back: cs=1, we=1, waddr=7, wdata=0xDEADBEEF, wstrb=4'hF, 1 edge. Then raddr_a=7 -> 0xDEADBEEF; raddr_b=8 -> 0.
- Byte strobes: entry 7 holds 0xDEADBEEF; write wdata=0x11223344 with wstrb=4'b0101 -> entry 7 reads 0xDE22BE44.
- Zero register and range: ZERO_REG=1, write 0xFFFFFFFF to waddr=0 -> rdata_a(0)=0. With DEPTH=20, write waddr=25 -> no entry changes; raddr=25 reads 0.
- Clear sequence: fill entries 1..31 with a nonzero pattern, pulse clr=1 for 1 edge.
  - busy=1 for exactly 32 edges.
  - After 10 edges, entry 9 reads 0 and entry 10 still holds data.
  - A write to entry 20 mid-clear is dropped.
  - After completion, all entries read 0.
  - Assert rst=0 mid-clear -> all entries 0 and busy=0 on that edge.
- Bypass (REG_FILE_BYPASS_EN defined): entry 3 holds 0xAAAAAAAA; write 0x55555555 with wstrb=4'b0011, raddr_a=3, in the same cycle -> rdata_a=0xAAAA5555 before the edge. Undefined -> rdata_a=0xAAAAAAAA before the edge.
